mantissa_normalizer: RTL and testbench

Sequential normalizer that feeds the rounder in the floating-point multiplier datapath. It takes the raw 2(M+1)-bit mantissa product and the pre-normalization exponent, and shifts the product left one bit per cycle until the leading one reaches the top bit. It then emits the hidden-bit-stripped fraction plus one guard bit, in the exact format the rounder consumes, together with the adjusted exponent and exception flags.

---
 rtl/fp_mult_pkg.sv | 19 +
 rtl/fp_result_packer.sv | 60 ++++++
 rtl/mantissa_normalizer.sv | 110 +++++++++++
 tb/tb_mantissa_normalizer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and default widths for the floating-point multiplier datapath.
package fp_mult_pkg;

    localparam int unsigned MANTISSA_WIDTH = 23;
    localparam int unsigned EXPONENT_WIDTH = 8;
    localparam int unsigned PRODUCT_WIDTH  = 2 * (MANTISSA_WIDTH + 1);

    typedef enum logic {
        IDLE,
        NORM
    } norm_state_t;

    typedef enum logic [1:0] {
        FIN_ZERO,
        FIN_NORMAL,
        FIN_UNDER
    } finish_kind_t;

endpackage

// File: rtl/fp_result_packer.sv
// Formats the normalized mantissa/exponent into rounder input and flags.
// Optional macro STICKY_EN folds discarded product bits into the guard bit.
module fp_result_packer
    import fp_mult_pkg::*;
#(
    parameter int unsigned MANTISSA_WIDTH = fp_mult_pkg::MANTISSA_WIDTH,
    parameter int unsigned EXPONENT_WIDTH = fp_mult_pkg::EXPONENT_WIDTH,
    parameter int unsigned PRODUCT_WIDTH  = 2 * (MANTISSA_WIDTH + 1)
) (
    input  logic [PRODUCT_WIDTH-1:0]         work_m,
    input  logic signed [EXPONENT_WIDTH+1:0] work_exp,
    input  finish_kind_t                     kind,
    output logic [MANTISSA_WIDTH:0]          normal_m,
    output logic [EXPONENT_WIDTH-1:0]        exponent,
    output logic                             zero,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned M = MANTISSA_WIDTH;
    localparam int unsigned E = EXPONENT_WIDTH;
    localparam int unsigned P = PRODUCT_WIDTH;

    localparam logic signed [E+1:0] EXP_MAX  = $signed({2'b00, {E{1'b1}}});
    localparam logic signed [E+1:0] EXP_ZERO = '0;

    logic guard;

`ifdef STICKY_EN
    assign guard = work_m[P-2-M] | (|work_m[P-3-M:0]);
`else
    assign guard = work_m[P-2-M];
`endif

    always_comb begin
        normal_m  = '0;
        exponent  = '0;
        zero      = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        case (kind)
            FIN_ZERO: zero = 1'b1;
            FIN_NORMAL: begin
                // A set leading bit with a non-positive exponent still has no
                // representable normal encoding, so it lands in underflow.
                if (work_exp <= EXP_ZERO) begin
                    underflow = 1'b1;
                end else if (work_exp >= EXP_MAX) begin
                    overflow = 1'b1;
                    exponent = '1;
                end else begin
                    exponent = work_exp[E-1:0];
                    normal_m = {work_m[P-2 -: M], guard};
                end
            end
            default: underflow = 1'b1;
        endcase
    end

endmodule

// File: rtl/mantissa_normalizer.sv
// Sequential one-bit-per-cycle mantissa normalizer feeding the rounder.
// Optional macro STICKY_EN (applied in fp_result_packer) adds sticky to the guard bit.
module mantissa_normalizer
    import fp_mult_pkg::*;
#(
    parameter int unsigned MANTISSA_WIDTH = fp_mult_pkg::MANTISSA_WIDTH,
    parameter int unsigned EXPONENT_WIDTH = fp_mult_pkg::EXPONENT_WIDTH,
    parameter int unsigned PRODUCT_WIDTH  = 2 * (MANTISSA_WIDTH + 1)
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        start_in,
    input  logic [PRODUCT_WIDTH-1:0]    product_m_in,
    input  logic [EXPONENT_WIDTH+1:0]   exponent_in,
    output logic [MANTISSA_WIDTH:0]     normal_m_out,
    output logic [EXPONENT_WIDTH-1:0]   exponent_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        zero_out,
    output logic                        overflow_out,
    output logic                        underflow_out
);

    localparam int unsigned P     = PRODUCT_WIDTH;
    localparam int unsigned EXP_W = EXPONENT_WIDTH + 2;

    localparam logic signed [EXP_W-1:0] EXP_ONE = 1;

    norm_state_t               state, next_state;
    logic [P-1:0]              work_m;
    logic signed [EXP_W-1:0]   work_exp;
    logic                      finish;
    finish_kind_t              kind;

    logic [MANTISSA_WIDTH:0]   pk_normal_m;
    logic [EXPONENT_WIDTH-1:0] pk_exponent;
    logic                      pk_zero, pk_overflow, pk_underflow;

    always_comb begin
        next_state = state;
        finish     = 1'b0;
        kind       = FIN_NORMAL;
        case (state)
            IDLE: if (start_in) next_state = NORM;
            NORM: begin
                if (work_m == '0) begin
                    finish = 1'b1;
                    kind   = FIN_ZERO;
                end else if (work_m[P-1]) begin
                    finish = 1'b1;
                    kind   = FIN_NORMAL;
                end else if (work_exp <= EXP_ONE) begin
                    finish = 1'b1;
                    kind   = FIN_UNDER;
                end
                if (finish) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            work_m        <= '0;
            work_exp      <= '0;
            normal_m_out  <= '0;
            exponent_out  <= '0;
            done_out      <= 1'b0;
            zero_out      <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            state    <= next_state;
            done_out <= finish;
            if (state == IDLE && start_in) begin
                work_m   <= product_m_in;
                work_exp <= $signed(exponent_in) + EXP_ONE;
            end else if (state == NORM && !finish) begin
                work_m   <= work_m << 1;
                work_exp <= work_exp - EXP_ONE;
            end
            if (finish) begin
                normal_m_out  <= pk_normal_m;
                exponent_out  <= pk_exponent;
                zero_out      <= pk_zero;
                overflow_out  <= pk_overflow;
                underflow_out <= pk_underflow;
            end
        end
    end

    assign busy_out = (state == NORM);

    fp_result_packer #(
        .MANTISSA_WIDTH (MANTISSA_WIDTH),
        .EXPONENT_WIDTH (EXPONENT_WIDTH),
        .PRODUCT_WIDTH  (PRODUCT_WIDTH)
    ) u_packer (
        .work_m    (work_m),
        .work_exp  (work_exp),
        .kind      (kind),
        .normal_m  (pk_normal_m),
        .exponent  (pk_exponent),
        .zero      (pk_zero),
        .overflow  (pk_overflow),
        .underflow (pk_underflow)
    );

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed scoreboard bench for mantissa_normalizer (M=23, E=8, P=48).
module tb_mantissa_normalizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] product = '0;
    logic [9:0]  exponent = '0;
    logic [23:0] normal_m;
    logic [7:0]  exponent_res;
    logic        busy, done, zero, overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [23:0] m;
        logic [7:0]  e;
        logic        z;
        logic        o;
        logic        u;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mantissa_normalizer #(
        .MANTISSA_WIDTH (23),
        .EXPONENT_WIDTH (8)
    ) dut (
        .clk_in        (clk),
        .reset_in      (reset),
        .start_in      (start),
        .product_m_in  (product),
        .exponent_in   (exponent),
        .normal_m_out  (normal_m),
        .exponent_out  (exponent_res),
        .busy_out      (busy),
        .done_out      (done),
        .zero_out      (zero),
        .overflow_out  (overflow),
        .underflow_out (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " normal_m"}, 32'(normal_m), 32'h0);
        check({tag, " exponent"}, 32'(exponent_res), 32'h0);
        check({tag, " flags"}, {29'b0, zero, overflow, underflow}, 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
    endtask

    // Drive a request at the current negedge (cycle 0); returns in cycle 1.
    task automatic start_req(input logic [47:0] p, input logic [9:0] e, input exp_t x, input logic push);
        product  = p;
        exponent = e;
        start    = 1'b1;
        if (push) sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        check("cycle1 busy", 32'(busy), 32'h1);
        check("cycle1 done low", 32'(done), 32'h0);
    endtask

    // Wait for done_out (bounded), then pop and compare; returns in the done cycle.
    task automatic wait_done(input string tag);
        int   cyc;
        exp_t x;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() == 0) begin
            check({tag, " scoreboard nonempty"}, 32'h0, 32'h1);
            return;
        end
        x = sb.pop_front();
        check({tag, " done seen"}, 32'(done), 32'h1);
        check({tag, " latency"}, 32'(cyc), 32'(x.lat));
        check({tag, " busy low at done"}, 32'(busy), 32'h0);
        check({tag, " normal_m"}, 32'(normal_m), 32'(x.m));
        check({tag, " exponent"}, 32'(exponent_res), 32'(x.e));
        check({tag, " flags zou"}, {29'b0, zero, overflow, underflow}, {29'b0, x.z, x.o, x.u});
    endtask

    exp_t x;
    logic [23:0] sticky_m;

    initial begin
`ifdef STICKY_EN
        sticky_m = 24'h800001;
`else
        sticky_m = 24'h800000;
`endif
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        x = '{m: 24'h000000, e: 8'd128, z: 1'b0, o: 1'b0, u: 1'b0, lat: 2};
        start_req(48'h8000_0000_0000, 10'd127, x, 1'b1);
        wait_done("normal");
        @(negedge clk);
        check("done one-cycle pulse", 32'(done), 32'h0);
        check("result held", 32'(exponent_res), 32'd128);

        x = '{m: 24'h800000, e: 8'd127, z: 1'b0, o: 1'b0, u: 1'b0, lat: 3};
        start_req(48'h6000_0000_0000, 10'd127, x, 1'b1);
        wait_done("one shift");

        x = '{m: 24'h000000, e: 8'hFF, z: 1'b0, o: 1'b1, u: 1'b0, lat: 2};
        start_req(48'h8000_0000_0000, 10'd254, x, 1'b1);
        wait_done("overflow");

        x = '{m: 24'h000000, e: 8'h00, z: 1'b1, o: 1'b0, u: 1'b0, lat: 2};
        start_req(48'h0, 10'd127, x, 1'b1);
        wait_done("zero");

        x = '{m: 24'h000000, e: 8'h00, z: 1'b0, o: 1'b0, u: 1'b1, lat: 12};
        start_req(48'h0000_0000_0001, 10'd10, x, 1'b1);
        wait_done("underflow");

        x = '{m: 24'h000000, e: 8'd81, z: 1'b0, o: 1'b0, u: 1'b0, lat: 49};
        start_req(48'h0000_0000_0001, 10'd127, x, 1'b1);
        wait_done("worst case");

        x = '{m: sticky_m, e: 8'd128, z: 1'b0, o: 1'b0, u: 1'b0, lat: 2};
        start_req(48'hC000_0000_0001, 10'd127, x, 1'b1);
        wait_done("sticky");

        // new request issued in the done cycle
        x = '{m: 24'h800000, e: 8'd127, z: 1'b0, o: 1'b0, u: 1'b0, lat: 3};
        start_req(48'h6000_0000_0000, 10'd127, x, 1'b1);
        wait_done("back to back");

        start_req(48'hC000_0000_0001, 10'd127, x, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("mid reset");
        check("mid reset busy", 32'(busy), 32'h0);
        repeat (4) begin
            @(negedge clk);
            check("no done after abort", 32'(done), 32'h0);
        end
        check("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
